// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO controller:
// output-stage depth, occupancy sizing and the RAM fetch-issue rule.
package fifo_pkg;

  localparam int FIFO_OUT_STAGE_DEPTH = 2;

  typedef logic [1:0] out_count_t;

  // Occupancy counts RAM words, the in-flight fetch and the output stage.
  function automatic int occupancyWidth(input int depth);
    return $clog2(depth + FIFO_OUT_STAGE_DEPTH + 1);
  endfunction

  // A fetch may start only if its word will have a slot when it lands next cycle.
  function automatic logic fetchIssue(
    input logic       memNotEmpty,
    input out_count_t outCount,
    input logic       inFlight,
    input logic       pop
  );
    int pending;
    pending = int'(outCount) + int'(inFlight) - int'(pop);
    return memNotEmpty && (pending < FIFO_OUT_STAGE_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_output_stage.sv
// Two-entry head/skid queue holding words fetched from the RAM; head is the
// show-ahead read data.
module fifo_output_stage
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enqueue,
  input  logic [DATAWIDTH-1:0] enqueueData,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] head,
  output out_count_t           outCount
);

  logic [DATAWIDTH-1:0] skid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      skid     <= '0;
      outCount <= '0;
    end else begin
      unique case ({enqueue, pop})
        2'b10: begin
          if (outCount == 2'd0) head <= enqueueData;
          else                  skid <= enqueueData;
          outCount <= outCount + 2'd1;
        end
        2'b01: begin
          head     <= skid;
          outCount <= outCount - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (outCount == 2'd1) begin
            head <= enqueueData;
          end else begin
            head <= skid;
            skid <= enqueueData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/simpleDualPortDualClockMemory.sv
// Simple dual-port RAM with independent write and read clocks and a
// registered read port (1-cycle latency, old data on same-address collision).
module simpleDualPortDualClockMemory #(
  parameter int DATAWIDTH    = 8,
  parameter int DATADEPTH    = 1024,
  parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
  input  logic                    writeClk,
  input  logic                    writeEnable,
  input  logic [ADDRESSWIDTH-1:0] writeAddress,
  input  logic [DATAWIDTH-1:0]    dataIn,
  input  logic                    readClk,
  input  logic                    readEnable,
  input  logic [ADDRESSWIDTH-1:0] readAddress,
  output logic [DATAWIDTH-1:0]    dataOut
);

  logic [DATAWIDTH-1:0] mem [DATADEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; a reset
  // loop over every word would force it into flops.
  always_ff @(posedge writeClk) begin
    if (writeEnable) mem[writeAddress] <= dataIn;
  end

  // NOTE: non-blocking assignments make a same-edge read of a written address
  // return the previous contents, independent of process ordering.
  always_ff @(posedge readClk) begin
    if (readEnable) dataOut <= mem[readAddress];
  end

endmodule

// File: rtl/sync_fifo_controller.sv
// Single-clock FIFO controller around one simpleDualPortDualClockMemory with a
// show-ahead valid/ready read port. Define FIFO_WATERMARK_EN for almostFull.
module sync_fifo_controller
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH       = 8,
  parameter int DATADEPTH       = 1024,
  parameter int ADDRESSWIDTH    = $clog2(DATADEPTH),
  parameter int COUNTWIDTH      = occupancyWidth(DATADEPTH),
  parameter int ALMOSTFULLLEVEL = DATADEPTH - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEn,
  input  logic [DATAWIDTH-1:0]  writeData,
  output logic                  full,
  input  logic                  readReady,
  output logic                  readValid,
  output logic [DATAWIDTH-1:0]  readData,
  output logic [COUNTWIDTH-1:0] count
`ifdef FIFO_WATERMARK_EN
  ,
  output logic                  almostFull
`endif
);

  localparam logic [ADDRESSWIDTH:0] MEM_FULL = (ADDRESSWIDTH + 1)'(DATADEPTH);

  logic [ADDRESSWIDTH-1:0] wrPtr;
  logic [ADDRESSWIDTH-1:0] rdPtr;
  logic [ADDRESSWIDTH:0]   memCount;
  logic                    inFlight;
  out_count_t              outCount;
  logic [DATAWIDTH-1:0]    ramData;
  logic                    push;
  logic                    pop;
  logic                    fetch;

  assign full      = (memCount == MEM_FULL);
  assign readValid = (outCount != 2'd0);
  assign push      = writeEn && !full;
  assign pop       = readValid && readReady;
  assign fetch     = fetchIssue(memCount != '0, outCount, inFlight, pop);
  assign count     = COUNTWIDTH'(memCount) + COUNTWIDTH'(inFlight) + COUNTWIDTH'(outCount);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      memCount <= '0;
      inFlight <= 1'b0;
    end else begin
      if (push)  wrPtr <= wrPtr + ADDRESSWIDTH'(1);
      if (fetch) rdPtr <= rdPtr + ADDRESSWIDTH'(1);
      unique case ({push, fetch})
        2'b10:   memCount <= memCount + (ADDRESSWIDTH + 1)'(1);
        2'b01:   memCount <= memCount - (ADDRESSWIDTH + 1)'(1);
        default: ;
      endcase
      // Reset drops this flag, so a RAM read still completing is never enqueued.
      inFlight <= fetch;
    end
  end

  simpleDualPortDualClockMemory #(
    .DATAWIDTH   (DATAWIDTH),
    .DATADEPTH   (DATADEPTH),
    .ADDRESSWIDTH(ADDRESSWIDTH)
  ) u_ram (
    .writeClk    (clk),
    .writeEnable (push),
    .writeAddress(wrPtr),
    .dataIn      (writeData),
    .readClk     (clk),
    .readEnable  (fetch),
    .readAddress (rdPtr),
    .dataOut     (ramData)
  );

  fifo_output_stage #(
    .DATAWIDTH(DATAWIDTH)
  ) u_out (
    .clk        (clk),
    .reset      (reset),
    .enqueue    (inFlight),
    .enqueueData(ramData),
    .pop        (pop),
    .head       (readData),
    .outCount   (outCount)
  );

`ifdef FIFO_WATERMARK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) almostFull <= 1'b0;
    else       almostFull <= (count >= COUNTWIDTH'(ALMOSTFULLLEVEL));
  end
`endif

  a_memcount_range: assert property (@(posedge clk) disable iff (reset)
    memCount <= MEM_FULL);
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count <= COUNTWIDTH'(DATADEPTH + FIFO_OUT_STAGE_DEPTH));
  a_stage_room: assert property (@(posedge clk) disable iff (reset)
    inFlight |-> (outCount < 2'd2 || pop));
  a_level_sane: assert property (@(posedge clk) disable iff (reset)
    ALMOSTFULLLEVEL <= DATADEPTH + FIFO_OUT_STAGE_DEPTH);

endmodule

// File: tb/tb_sync_fifo_controller.sv
// Self-checking bench for sync_fifo_controller at DATADEPTH=16: vector table for
// latency/simultaneous events, scoreboarded sequences for fill, wrap and reset.
module tb_sync_fifo_controller;

  localparam int DW  = 8;
  localparam int DD  = 16;
  localparam int CW  = $clog2(DD + 3);
  localparam int AFL = 12;
  localparam int CAP = DD + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          writeEn = 1'b0;
  logic [DW-1:0] writeData = '0;
  logic          readReady = 1'b0;
  logic          full;
  logic          readValid;
  logic [DW-1:0] readData;
  logic [CW-1:0] count;
`ifdef FIFO_WATERMARK_EN
  logic          almostFull;
`endif

  sync_fifo_controller #(
    .DATAWIDTH      (DW),
    .DATADEPTH      (DD),
    .ALMOSTFULLLEVEL(AFL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .writeEn  (writeEn),
    .writeData(writeData),
    .full     (full),
    .readReady(readReady),
    .readValid(readValid),
    .readData (readData),
    .count    (count)
`ifdef FIFO_WATERMARK_EN
    ,
    .almostFull(almostFull)
`endif
  );

  always #5 clk = ~clk;

  int          nVec = 0;
  int          nErr = 0;
  int          nPopped = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          rr;
    logic          expValid;
    logic [DW-1:0] expData;
    logic [CW-1:0] expCount;
    logic          expFull;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    writeEn = 1'b0;
    readReady = 1'b0;
    #1;
    check("reset_valid", readValid, 0);
    check("reset_count", count, 0);
    check("reset_full", full, 0);
    check("reset_data", readData, 0);
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    nPopped = 0;
  endtask

  // One cycle: drive inputs, score any pop, queue the word if the push is accepted.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic rr, input logic accept);
    writeEn = we;
    writeData = wd;
    readReady = rr;
    if (readValid && readReady) begin
      nPopped++;
      if (sb.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_word: got %0h, expected none (t=%0t)", readData, $time);
      end else begin
        check("sb_data", readData, sb.pop_front());
      end
    end
    if (we && accept) sb.push_back(wd);
    tick();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && sb.size() != 0; n++) step(1'b0, '0, 1'b1, 1'b0);
    check({name, "_left"}, sb.size(), 0);
    check({name, "_count"}, count, 0);
    check({name, "_valid"}, readValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nPushed;
    int k;

    // we, wd, rr | valid, data, count, full  -- one row per cycle after reset
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
    vecs[9]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 5'd2, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 5'd2, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

    doReset();
    for (int i = 0; i < 14; i++) begin
      writeEn = vecs[i].we;
      writeData = vecs[i].wd;
      readReady = vecs[i].rr;
      check($sformatf("vec%0d_valid", i), readValid, vecs[i].expValid);
      check($sformatf("vec%0d_count", i), count, vecs[i].expCount);
      check($sformatf("vec%0d_full", i), full, vecs[i].expFull);
      if (vecs[i].expValid) check($sformatf("vec%0d_data", i), readData, vecs[i].expData);
      tick();
    end

    // Fill with the consumer stalled: capacity is the RAM plus the two stage slots.
    doReset();
    for (int i = 0; i < CAP + 2; i++) begin
      check($sformatf("fill%0d_count", i), count, (i < CAP) ? i : CAP);
      check($sformatf("fill%0d_full", i), full, (i >= CAP) ? 1 : 0);
      step(1'b1, 8'(8'h40 + i), 1'b0, i < CAP);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("full_full", full, 1);
    check("full_count", count, CAP);
    check("full_valid", readValid, 1);

    // Streaming from full: the first push meets full and is refused, so the
    // occupancy then holds one below capacity while moving a word each way.
    for (int i = 0; i < 30; i++) begin
      if (i == 0) check("stream_full0", full, 1);
      else begin
        check($sformatf("stream%0d_count", i), count, CAP - 1);
        check($sformatf("stream%0d_full", i), full, 0);
      end
      step(1'b1, 8'(8'h80 + i), 1'b1, i > 0);
    end
    drain("stream");

    // 40 words through a 16-deep RAM with a random consumer: pointers wrap.
    doReset();
    nPushed = 0;
    for (int n = 0; n < 2000 && (nPushed < 40 || sb.size() != 0); n++) begin
      logic we;
      we = (nPushed < 40) && ((nPushed - nPopped) < 12);
      step(we, 8'(nPushed), $urandom_range(0, 3) != 0, 1'b1);
      if (we) nPushed++;
    end
    check("wrap_pushed", nPushed, 40);
    check("wrap_popped", nPopped, 40);
    drain("wrap");

    // Reset while a fetch is in flight and the stage holds a word.
    doReset();
    step(1'b1, 8'hC1, 1'b0, 1'b1);
    step(1'b1, 8'hC2, 1'b0, 1'b1);
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    check("midrst_pre_count", count, 3);
    writeEn = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_async_count", count, 0);
    check("midrst_async_valid", readValid, 0);
    tick();
    check("midrst_count", count, 0);
    check("midrst_valid", readValid, 0);
    check("midrst_full", full, 0);
    reset = 1'b0;
    sb.delete();
    writeEn = 1'b1;
    writeData = 8'h3C;
    tick();
    writeEn = 1'b0;
    for (k = 1; k < 10; k++) begin
      if (readValid) break;
      tick();
    end
    check("midrst_latency", k, 3);
    check("midrst_data", readData, 8'h3C);
    check("midrst_count1", count, 1);
    readReady = 1'b1;
    tick();
    readReady = 1'b0;
    check("midrst_empty", count, 0);

`ifdef FIFO_WATERMARK_EN
    // Watermark lags count by one cycle, both rising and falling.
    doReset();
    begin
      int prevCnt;
      int cnt;
      prevCnt = 0;
      for (int t = 0; t < 22; t++) begin
        cnt = (t <= 14) ? t : 28 - t;
        check($sformatf("wm%0d_count", t), count, cnt);
        check($sformatf("wm%0d_almostFull", t), almostFull, (prevCnt >= AFL) ? 1 : 0);
        prevCnt = cnt;
        step(t < 14, 8'(8'hD0 + t), t >= 14, 1'b1);
      end
    end
    drain("wm");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
